// File: rtl/cpu_pkg.sv
// Shared definitions for the instruction-memory loader: frame header value,
// loader FSM encoding, word-count width and the instruction word layout.
package cpu_pkg;

  // Start-of-frame byte used when the loader is not overridden.
  localparam logic [7:0] HEADER_DEFAULT = 8'hA5;

  // Loader FSM encoding. Kept as plain constants so older tools and
  // netlist viewers show stable, readable codes.
  localparam int STATE_W = 3;
  localparam logic [STATE_W-1:0] ST_IDLE  = 3'd0;
  localparam logic [STATE_W-1:0] ST_LEN   = 3'd1;
  localparam logic [STATE_W-1:0] ST_HI    = 3'd2;
  localparam logic [STATE_W-1:0] ST_LO    = 3'd3;
  localparam logic [STATE_W-1:0] ST_WRITE = 3'd4;
  localparam logic [STATE_W-1:0] ST_CHK   = 3'd5;
  localparam logic [STATE_W-1:0] ST_DONE  = 3'd6;
  localparam logic [STATE_W-1:0] ST_ERR   = 3'd7;

  // A LEN byte of 0 stands for 256 words, so the counter needs 9 bits.
  localparam int WCNT_W = 9;

  // Register-register form: [15:12] opcode, [11:8] rs, [7:4] rt, [3:0] rd.
  typedef struct packed {
    logic [3:0] opcode;
    logic [3:0] rs;
    logic [3:0] rt;
    logic [3:0] rd;
  } instr_rrr_t;

  // Immediate form: [15:12] opcode, [11:8] rs, [7:0] imm.
  typedef struct packed {
    logic [3:0] opcode;
    logic [3:0] rs;
    logic [7:0] imm;
  } instr_imm_t;

  // Both views overlay the same 16-bit instruction word.
  typedef union packed {
    instr_rrr_t rrr;
    instr_imm_t ri;
  } instr_t;

  // Convert the LEN byte of a frame into a word count.
  function automatic logic [WCNT_W-1:0] len_to_words(input logic [7:0] len);
    return (len == 8'd0) ? 9'd256 : {1'b0, len};
  endfunction

  // States in which the loader is willing to take a byte from upstream.
  function automatic logic state_takes_byte(input logic [STATE_W-1:0] st);
    return (st == ST_IDLE) || (st == ST_LEN) || (st == ST_HI) ||
           (st == ST_LO)   || (st == ST_CHK);
  endfunction

endpackage

// File: rtl/xor_acc8.sv
// Byte-wide XOR accumulator used for the frame checksum.
module xor_acc8 (
  input  logic       clk_i,
  input  logic       clr_i,
  input  logic       en_i,
  input  logic [7:0] din_i,
  output logic [7:0] sum_o
);

  logic [7:0] sum_q;

  // Clear has priority over accumulate so a restart never mixes frames.
  always_ff @(posedge clk_i) begin
    if (clr_i) begin
      sum_q <= 8'h00;
    end else if (en_i) begin
      sum_q <= sum_q ^ din_i;
    end
  end

  assign sum_o = sum_q;

endmodule

// File: rtl/mem_loader.sv
// Instruction-memory loader: receives a framed byte stream
// (HEADER, LEN, LEN 16-bit words high byte first, XOR checksum), writes
// each word into instruction memory and holds the CPU in reset while loading.
module mem_loader
  import cpu_pkg::*;
#(
  parameter logic [7:0] HEADER = HEADER_DEFAULT,
  parameter int         ADDR_W = 8
) (
  input  logic              Clk100_Mhz,
  input  logic              Clr,
  input  logic [7:0]        InData,
  input  logic              InValid,
  output logic              InReady,
  output logic              MemWe,
  output logic [ADDR_W-1:0] MemAddr,
  output logic [15:0]       MemData,
  output logic              CpuHold,
  output logic              Done,
  output logic              Error
);

  logic [STATE_W-1:0] state_q, state_d;
  logic [ADDR_W-1:0]  addr_q, addr_d;
  instr_t             data_q, data_d;
  logic [WCNT_W-1:0]  wcnt_q, wcnt_d;
  logic               hold_q, hold_d;
  logic               done_q, done_d;
  logic               err_q, err_d;

  logic               ready;
  logic               accept;
  logic               acc_clr;
  logic               acc_en;
  logic [7:0]         chk_sum;

  assign ready  = state_takes_byte(state_q);
  assign accept = InValid && ready;

  // The checksum restarts with every LEN byte, so stale data from an
  // abandoned or failed frame never leaks into the next one.
  assign acc_clr = Clr || ((state_q == ST_LEN) && accept);
  assign acc_en  = accept && ((state_q == ST_HI) || (state_q == ST_LO));

  xor_acc8 u_chk (
    .clk_i (Clk100_Mhz),
    .clr_i (acc_clr),
    .en_i  (acc_en),
    .din_i (InData),
    .sum_o (chk_sum)
  );

  // Next-state and datapath decisions for one frame byte at a time.
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    data_d  = data_q;
    wcnt_d  = wcnt_q;
    hold_d  = hold_q;
    done_d  = done_q;
    err_d   = err_q;

    case (state_q)
      ST_IDLE: begin
        // Anything other than the header is line noise and is dropped.
        if (accept && (InData == HEADER)) begin
          state_d = ST_LEN;
          hold_d  = 1'b1;
          done_d  = 1'b0;
          err_d   = 1'b0;
        end
      end

      ST_LEN: begin
        if (accept) begin
          wcnt_d  = len_to_words(InData);
          addr_d  = '0;
          state_d = ST_HI;
        end
      end

      ST_HI: begin
        if (accept) begin
          data_d.ri.opcode = InData[7:4];
          data_d.ri.rs     = InData[3:0];
          state_d          = ST_LO;
        end
      end

      ST_LO: begin
        if (accept) begin
          data_d.ri.imm = InData;
          state_d       = ST_WRITE;
        end
      end

      ST_WRITE: begin
        // Single-cycle write slot; a HEADER-valued data byte never
        // resynchronises because only IDLE looks for the header.
        addr_d  = addr_q + ADDR_W'(1);
        wcnt_d  = wcnt_q - WCNT_W'(1);
        state_d = (wcnt_q == WCNT_W'(1)) ? ST_CHK : ST_HI;
      end

      ST_CHK: begin
        if (accept) begin
          if (InData == chk_sum) begin
            state_d = ST_DONE;
            done_d  = 1'b1;
            err_d   = 1'b0;
            hold_d  = 1'b0;
          end else begin
            // Keep the CPU parked on a corrupt image until a good reload.
            state_d = ST_ERR;
            done_d  = 1'b0;
            err_d   = 1'b1;
            hold_d  = 1'b1;
          end
        end
      end

      ST_DONE: state_d = ST_IDLE;
      ST_ERR:  state_d = ST_IDLE;

      default: state_d = ST_IDLE;
    endcase
  end

  // State and datapath registers with synchronous clear.
  always_ff @(posedge Clk100_Mhz) begin
    if (Clr) begin
      state_q <= ST_IDLE;
      addr_q  <= '0;
      data_q  <= '0;
      wcnt_q  <= '0;
      hold_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      wcnt_q  <= wcnt_d;
      hold_q  <= hold_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  assign InReady = ready;
  assign MemWe   = (state_q == ST_WRITE);
  assign MemAddr = addr_q;
  assign MemData = data_q;
  assign CpuHold = hold_q;
  assign Done    = done_q;
  assign Error   = err_q;

endmodule
